uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter, the successor to the fixed 8N1 serialiser.
//  Adds a write FIFO with valid/ready handshake, configurable data width, stop-bit
//  count and bit period (bclk cycles per bit), plus optional parity.
//  Sits between the host register interface and the tx pin. Frames are sent
//  back-to-back while the FIFO holds data.
// PARAMETERS
//  DATA_BITS     8   data bits per frame, 5..9, sent LSB first
//  STOP_BITS     1   stop bits per frame, 1 or 2
//  CLKS_PER_BIT  16  bclk cycles per serial bit, >=1
//  FIFO_DEPTH    4   FIFO entries, power of two, >=2
//  PARITY_ODD    0   1=odd parity, 0=even; only used with UART_TX_PARITY_EN
// PORTS
//  bclk        in   1                      clock; all logic on posedge
//  rst_n       in   1                      async reset, active-low
//  wr_data     in   DATA_BITS              word to transmit
//  wr_valid    in   1                      wr_data valid
//  wr_ready    out  1                      FIFO can accept; write = wr_valid&&wr_ready
//  tx_data     out  1                      serial line, idle high; registered
//  tx_status   out  1                      1 while a frame is on the line
//  fifo_count  out  $clog2(FIFO_DEPTH)+1   entries held, 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset (rst_n low, async): tx_data=1, tx_status=0, wr_ready=1, fifo_count=0,
//   FSM=IDLE, FIFO pointers cleared. A frame in flight is abandoned and the line
//   returns high at once. Data in the FIFO is lost.
//  FIFO: wr_ready = (fifo_count != FIFO_DEPTH), based on the registered count.
//   When full, a write is refused even if a pop happens in the same cycle.
//   A write and a pop in the same cycle leave fifo_count unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//  FSM states: IDLE, START, DATA, PARITY, STOP. A bit counter (0..CLKS_PER_BIT-1)
//   and a bit index (0..DATA_BITS-1 or STOP_BITS-1) control state changes.
//  IDLE: tx_data=1, tx_status=0. If the FIFO is non-empty: pop the head into the
//   shift register and go to START.
//   Write at edge k into an empty FIFO -> pop at edge k+1 -> tx_data=0 from k+1.
//  START: tx_data=0 for CLKS_PER_BIT cycles, then DATA.
//  DATA: tx_data=shift[0]; shift right at the end of each bit period. After
//   DATA_BITS bits go to PARITY (macro defined) or STOP.
//  PARITY: tx_data = ^data ^ PARITY_ODD for CLKS_PER_BIT cycles, then STOP.
//  STOP: tx_data=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   On the last cycle: if the FIFO is non-empty, pop and go directly to START
//   (no idle gap); otherwise go to IDLE.
//  tx_status = 1 in START/DATA/PARITY/STOP and 0 in IDLE.
//   tx_status is registered alongside tx_data.
//  Frame length = CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS), where P=1 with parity.
//  wr_data is sampled only on an accepted write; later changes have no effect.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: the PARITY state exists and PARITY_ODD is honoured.
//  Not defined: the PARITY state is not built, DATA goes to STOP, and PARITY_ODD
//   is ignored.
// TESTING
//  (DATA_BITS=8, STOP_BITS=1, CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
//  1. Write 0xA5, no parity -> line 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
//     Start bit begins 1 cycle after the write; tx_status high for 40 cycles.
//  2. Write 0xA5, parity macro, PARITY_ODD=0 -> parity bit 0, frame 44 cycles.
//     Same with PARITY_ODD=1 -> parity bit 1.
//  3. Write 5 words back-to-back with the line busy -> 5th word: wr_ready=0 until
//     the first pop. All 5 frames sent with no idle gap; fifo_count reaches 0 last.
//  4. STOP_BITS=2, write 0x00 -> start + 8 zeros, then 8 cycles high before IDLE.
//  5. rst_n low mid-DATA with 2 words queued -> tx_data=1 and tx_status=0
//     immediately, fifo_count=0. After release, the line stays idle.
//  6. Write while full and the FSM pops in the same cycle -> write refused.
//     fifo_count goes FIFO_DEPTH-1, and the refused word is never sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-fed UART transmitter; parity stage built only with UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          bclk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx_data,
  output logic                          tx_status,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
  logic                  parity_bit;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 wr_en;
  logic                 pop;
  logic                 bit_end;
  logic                 stop_last;

  logic [2:0]           state;
  logic [CW-1:0]        clk_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;

  // Ready comes from the registered count only, so a same-cycle pop never frees a full FIFO.
  assign wr_ready  = (fifo_count != (AW+1)'(FIFO_DEPTH));
  assign wr_en     = wr_valid && wr_ready;
  assign head      = mem[rd_ptr];
  assign bit_end   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign stop_last = (state == STOP) && bit_end && (bit_idx == IW'(STOP_BITS - 1));
  assign pop       = (fifo_count != '0) && ((state == IDLE) || stop_last);

  always_ff @(posedge bclk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // tx_data/tx_status are loaded with the value of the state being entered.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_data    <= 1'b1;
      tx_status  <= 1'b0;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift      <= head;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^head) ^ 1'(PARITY_ODD);
`endif
            state      <= START;
            tx_data    <= 1'b0;
            tx_status  <= 1'b1;
            clk_cnt    <= '0;
            bit_idx    <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx_data <= shift[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == IW'(DATA_BITS - 1)) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx_data <= parity_bit;
`else
              state   <= STOP;
              tx_data <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx_data <= shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= STOP;
            tx_data <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == IW'(STOP_BITS - 1)) begin
              bit_idx <= '0;
              if (pop) begin
                shift      <= head;
`ifdef UART_TX_PARITY_EN
                parity_bit <= (^head) ^ 1'(PARITY_ODD);
`endif
                state      <= START;
                tx_data    <= 1'b0;
              end else begin
                state      <= IDLE;
                tx_data    <= 1'b1;
                tx_status  <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          tx_data   <= 1'b1;
          tx_status <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo; follows UART_TX_PARITY_EN when defined.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FLEN  = CPB * (1 + 8 + P + 1);
  localparam int FLEN2 = CPB * (1 + 8 + P + 2);

  logic       bclk;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       tx_data;
  logic       tx_status;
  logic [2:0] fifo_count;

  logic [7:0] w2_data;
  logic       w2_valid;
  logic       w2_ready;
  logic       tx_data2;
  logic       tx_status2;
  logic [2:0] fifo_count2;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb[$];
  int         busy_cnt = 0;
  int         gap_cnt  = 0;
  logic       gap_en   = 0;

  logic        m_active = 0;
  int          m_cyc    = 0;
  logic [15:0] m_bits;
  logic [7:0]  m_exp;

  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut (
    .bclk(bclk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .tx_data(tx_data), .tx_status(tx_status), .fifo_count(fifo_count)
  );

  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(2), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_ODD(1)) dut2 (
    .bclk(bclk), .rst_n(rst_n), .wr_data(w2_data), .wr_valid(w2_valid), .wr_ready(w2_ready),
    .tx_data(tx_data2), .tx_status(tx_status2), .fifo_count(fifo_count2)
  );

  initial begin
    bclk = 1'b0;
    forever #5 bclk = ~bclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge bclk) begin
    if (tx_status) busy_cnt++;
    if (gap_en && !tx_status && sb.size() != 0) gap_cnt++;
  end

  // Frame decoder: samples mid-bit and checks each frame against the head of the scoreboard.
  always @(negedge bclk) begin
    if (!rst_n) begin
      m_active = 1'b0;
    end else begin
      if (!m_active && tx_status && !tx_data) begin
        m_active = 1'b1;
        m_cyc    = 0;
        m_bits   = '0;
      end else if (m_active) begin
        m_cyc++;
      end
      if (m_active) begin
        if (m_cyc % CPB == CPB / 2) m_bits[m_cyc / CPB] = tx_data;
        if (m_cyc == FLEN - 1) begin
          m_active = 1'b0;
          chk("frame_start", m_bits[0], 0);
          chk("frame_stop", m_bits[9 + P], 1);
          if (sb.size() == 0) begin
            chk("extra_frame", 1, 0);
          end else begin
            m_exp = sb.pop_front();
            chk("frame_data", m_bits[8:1], m_exp);
`ifdef UART_TX_PARITY_EN
            chk("frame_parity", m_bits[9], ^m_exp);
`endif
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, output int waited);
    int n;
    n = 0;
    @(negedge bclk);
    wr_data  = d;
    wr_valid = 1'b1;
    while (!wr_ready && n < 2000) begin
      @(negedge bclk);
      n++;
    end
    if (!wr_ready) chk("push_timeout", 0, 1);
    @(posedge bclk);
    #1;
    wr_valid = 1'b0;
    wr_data  = ~d;
    if (n < 2000) sb.push_back(d);
    waited = n;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge bclk);
    while ((tx_status || fifo_count != 0) && n < 3000) begin
      @(negedge bclk);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 0, 1);
  endtask

  int         w;
  int         n;
  logic [7:0] words[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    w2_valid = 1'b0;
    w2_data  = '0;
    repeat (3) @(posedge bclk);
    #1;
    chk("rst_tx_data", tx_data, 1);
    chk("rst_tx_status", tx_status, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_tx_data2", tx_data2, 1);
    rst_n = 1'b1;
    repeat (2) @(posedge bclk);

    // Single 0xA5 frame: start one cycle after the accepting edge.
    busy_cnt = 0;
    @(negedge bclk);
    wr_data  = 8'hA5;
    wr_valid = 1'b1;
    @(posedge bclk);
    #1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    sb.push_back(8'hA5);
    chk("t1_line_at_k", tx_data, 1);
    chk("t1_count_at_k", fifo_count, 1);
    @(posedge bclk);
    #1;
    chk("t1_line_at_k1", tx_data, 0);
    chk("t1_status_at_k1", tx_status, 1);
    wait_idle();
    chk("t1_busy_cycles", busy_cnt, FLEN);

    for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)), w);
    wait_idle();

    // Back-to-back frames with a full FIFO holding off the fifth write.
    push(8'h3C, w);
    @(posedge bclk);
    #1;
    gap_cnt = 0;
    gap_en  = 1'b1;
    for (int i = 0; i < 4; i++) push(words[i], w);
    @(negedge bclk);
    chk("t3_full_ready", wr_ready, 0);
    chk("t3_full_count", fifo_count, 4);
    push(words[4], w);
    chk("t3_fifth_waited", (w > 0), 1);
    wait_idle();
    gap_en = 1'b0;
    chk("t3_gap_cycles", gap_cnt, 0);
    chk("t3_sb_left", sb.size(), 0);
    chk("t3_count_end", fifo_count, 0);

    // Write held while full across the pop edge must be refused.
    push(8'h3C, w);
    for (int i = 0; i < 4; i++) push(words[i] ^ 8'hF0, w);
    n = 0;
    while (n < 200) begin
      @(negedge bclk);
      if (fifo_count != 4) break;
      wr_data  = 8'hEE;
      wr_valid = 1'b1;
      n++;
    end
    wr_valid = 1'b0;
    chk("t6_count_after_pop", fifo_count, 3);
    wait_idle();
    chk("t6_sb_left", sb.size(), 0);

    // Two stop bits on the second instance, checked cycle by cycle.
    @(negedge bclk);
    w2_data  = 8'h00;
    w2_valid = 1'b1;
    @(posedge bclk);
    #1;
    w2_valid = 1'b0;
    w2_data  = 8'hFF;
    @(negedge bclk);
    chk("t4_line_idle_k", tx_data2, 1);
    for (int i = 0; i < FLEN2; i++) begin
      logic eb;
      int   b;
      @(negedge bclk);
      b  = i / CPB;
      eb = (b <= 8) ? 1'b0 : ((P == 1 && b == 9) ? 1'b1 : 1'b1);
      chk("t4_line", {tx_status2, tx_data2}, {1'b1, eb});
    end
    @(negedge bclk);
    chk("t4_status_end", tx_status2, 0);
    chk("t4_line_end", tx_data2, 1);

    // Reset mid-frame with words queued.
    push(8'h96, w);
    push(8'h12, w);
    push(8'h34, w);
    repeat (8) @(posedge bclk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_tx_data", tx_data, 1);
    chk("t5_tx_status", tx_status, 0);
    chk("t5_fifo_count", fifo_count, 0);
    chk("t5_wr_ready", wr_ready, 1);
    sb.delete();
    @(negedge bclk);
    repeat (2) @(posedge bclk);
    #2;
    rst_n = 1'b1;
    busy_cnt = 0;
    repeat (30) @(negedge bclk);
    chk("t5_busy_after", busy_cnt, 0);
    chk("t5_line_after", tx_data, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
